acq_trigger_ctrl: RTL and testbench

ACQ_TRIGGER_CTRL -- requirements
Module: acq_trigger_ctrl

---
 rtl/acq_pkg.sv | 27 ++
 rtl/trig_detect.sv | 57 +++++
 rtl/acq_trigger_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_acq_trigger_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// ---------------------------------------------------------------------------
// acq_pkg -- shared definitions for the acquisition trigger controller.
//
// Contents:
//   acq_state_t   controller state encoding (exposed on the debug port)
//   EDGE_RISING   trig_edge_i value selecting a rising-edge trigger
//   EDGE_FALLING  trig_edge_i value selecting a falling-edge trigger
//   is_busy()     true for states in which samples are written
// ---------------------------------------------------------------------------
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POSTTRIG  = 3'd3,
        ST_DONE      = 3'd4
    } acq_state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    function automatic logic is_busy(input acq_state_t s);
        return (s == ST_PRETRIG) || (s == ST_WAIT_TRIG) || (s == ST_POSTTRIG);
    endfunction

endpackage

// File: rtl/trig_detect.sv
// ---------------------------------------------------------------------------
// trig_detect -- threshold-crossing detector for the acquisition controller.
//
// Keeps the previously written sample and compares it with the current one
// against the latched threshold. o_hit is combinational on the current
// sample so the controller can act on it in the same cycle it is accepted.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst          synchronous active-high reset
//   i_clear      forget the previous sample (new run armed)
//   i_sample_en  current sample is being written; remember it
//   i_data       current sample
//   i_level      trigger threshold, unsigned
//   i_edge       EDGE_RISING / EDGE_FALLING
//   o_hit        current sample crosses the threshold w.r.t. previous one
// ---------------------------------------------------------------------------
module trig_detect
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_sample_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_level,
    input  logic                  i_edge,
    output logic                  o_hit
);

    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_vld;
    logic                  w_rise;
    logic                  w_fall;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (i_clear) begin
            r_prev_vld <= 1'b0;
        end else if (i_sample_en) begin
            r_prev     <= i_data;
            r_prev_vld <= 1'b1;
        end
    end

    always_comb begin
        w_rise = (r_prev < i_level) && (i_data >= i_level);
        w_fall = (r_prev > i_level) && (i_data <= i_level);
        // The first sample of a run has no predecessor and can never trigger.
        o_hit  = r_prev_vld && ((i_edge == EDGE_FALLING) ? w_fall : w_rise);
    end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// acq_trigger_ctrl -- pre/post-trigger capture controller for an ADC stream.
//
// After start_i the block writes pre_trig samples, then keeps writing while
// it waits for a threshold crossing, writes the trigger sample and post_trig
// further samples, and stops in DONE. Write address wraps modulo the depth.
//
// Optional feature macro: ACQ_AUTO_TRIG_EN
//   defined   : in WAIT_TRIG the AUTO_TIMEOUT-th sample without a crossing is
//               taken as the trigger sample.
//   undefined : WAIT_TRIG waits indefinitely, no timeout counter exists.
//
// Ports:
//   clk_i, rst             clock, synchronous active-high reset
//   start_i, stop_i        arm / abort pulses (stop wins)
//   adc_data_i, adc_rdy_i  ADC sample and its valid
//   adc_ack_o              ADC acknowledge
//   trig_level_i/edge_i    threshold and edge select (latched at start)
//   pre_trig_i/post_trig_i sample counts around the trigger (latched at start)
//   wr_en_o/addr_o/data_o  capture buffer write port, registered
//   trig_addr_o            buffer address of last trigger sample
//   busy_o, done_o         run in progress / run complete
//   dbg_state_o            current controller state
// ---------------------------------------------------------------------------
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [DATA_WIDTH-1:0] adc_data_i,
    input  logic                  adc_rdy_i,
    output logic                  adc_ack_o,
    input  logic [DATA_WIDTH-1:0] trig_level_i,
    input  logic                  trig_edge_i,
    input  logic [ADDR_WIDTH-1:0] pre_trig_i,
    input  logic [ADDR_WIDTH-1:0] post_trig_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [ADDR_WIDTH-1:0] trig_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output acq_state_t            dbg_state_o
);

    // ADC handshake: the ADC presents a sample with adc_rdy_i=1 and it is
    // consumed in that same cycle (adc_ack_o mirrors adc_rdy_i); there is no
    // back-pressure, so samples arriving outside a busy state are dropped.
    assign adc_ack_o = adc_rdy_i;

    acq_state_t            r_state;
    acq_state_t            w_state_next;

    logic [DATA_WIDTH-1:0] r_level;
    logic                  r_edge;
    logic [ADDR_WIDTH-1:0] r_pre;
    logic [ADDR_WIDTH-1:0] r_post;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_trig_addr;

    logic                  w_arm;
    logic                  w_write;
    logic                  w_fire;
    logic                  w_hit;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    assign w_cnt_inc = r_cnt + ADDR_WIDTH'(1);

`ifdef ACQ_AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT) + 1;

    logic [TO_W-1:0] r_to_cnt;

    // Counts WAIT_TRIG samples; the sample that would make the count reach
    // AUTO_TIMEOUT is itself the forced trigger.
    assign w_timeout = (r_to_cnt == TO_W'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_arm) begin
            r_to_cnt <= '0;
        end else if (w_write && (r_state == ST_WAIT_TRIG) && !w_fire) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    trig_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig_detect (
        .clk_i       (clk_i),
        .rst         (rst),
        .i_clear     (w_arm),
        .i_sample_en (w_write),
        .i_data      (adc_data_i),
        .i_level     (r_level),
        .i_edge      (r_edge),
        .o_hit       (w_hit)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_arm        = 1'b0;
        w_write      = 1'b0;
        w_fire       = 1'b0;
        w_cnt_next   = r_cnt;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_arm        = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = (pre_trig_i == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
                end
            end
            ST_PRETRIG: begin
                if (adc_rdy_i) begin
                    w_write = 1'b1;
                    if (w_cnt_inc == r_pre) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_WAIT_TRIG;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            ST_WAIT_TRIG: begin
                if (adc_rdy_i) begin
                    w_write = 1'b1;
                    if (w_hit || w_timeout) begin
                        w_fire       = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = (r_post == '0) ? ST_DONE : ST_POSTTRIG;
                    end
                end
            end
            ST_POSTTRIG: begin
                if (adc_rdy_i) begin
                    w_write    = 1'b1;
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == r_post) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a write or trigger that the
        // current sample would otherwise have produced.
        if (stop_i) begin
            w_state_next = ST_IDLE;
            w_arm        = 1'b0;
            w_write      = 1'b0;
            w_fire       = 1'b0;
            w_cnt_next   = r_cnt;
        end
    end

    // Datapath: configuration latch, counters, write port, trigger address
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_level     <= '0;
            r_edge      <= EDGE_RISING;
            r_pre       <= '0;
            r_post      <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_trig_addr <= '0;
        end else begin
            r_wr_en <= w_write;
            r_cnt   <= w_cnt_next;
            if (w_arm) begin
                r_level <= trig_level_i;
                r_edge  <= trig_edge_i;
                r_pre   <= pre_trig_i;
                r_post  <= post_trig_i;
                r_ptr   <= '0;
            end
            if (w_write) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= adc_data_i;
                r_ptr     <= r_ptr + ADDR_WIDTH'(1);
            end
            if (w_fire) begin
                r_trig_addr <= r_ptr;
            end
        end
    end

    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign trig_addr_o = r_trig_addr;
    assign busy_o      = is_busy(r_state);
    assign done_o      = (r_state == ST_DONE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acq_trigger_ctrl -- self-checking bench for acq_trigger_ctrl.
// A run-level reference model (samples of the current run kept in a queue,
// trigger and completion derived from sample indices) predicts every output
// each cycle; directed scenarios pin the model with literal expectations.
// Honours ACQ_AUTO_TRIG_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_acq_trigger_ctrl;
    import acq_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int ATO   = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk_i        = 1'b0;
    logic          rst          = 1'b1;
    logic          start_i      = 1'b0;
    logic          stop_i       = 1'b0;
    logic [DW-1:0] adc_data_i   = '0;
    logic          adc_rdy_i    = 1'b0;
    logic [DW-1:0] trig_level_i = '0;
    logic          trig_edge_i  = 1'b0;
    logic [AW-1:0] pre_trig_i   = '0;
    logic [AW-1:0] post_trig_i  = '0;
    logic          adc_ack_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [AW-1:0] trig_addr_o;
    logic          busy_o;
    logic          done_o;
    acq_state_t    dbg_state_o;

    acq_trigger_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AUTO_TIMEOUT (ATO)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .adc_data_i   (adc_data_i),
        .adc_rdy_i    (adc_rdy_i),
        .adc_ack_o    (adc_ack_o),
        .trig_level_i (trig_level_i),
        .trig_edge_i  (trig_edge_i),
        .pre_trig_i   (pre_trig_i),
        .post_trig_i  (post_trig_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .trig_addr_o  (trig_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_busy = 0;
    bit            m_done = 0;
    int            m_pre = 0, m_post = 0, m_lvl = 0, m_trig = -1;
    bit            m_edge = 0;
    int            run_q[$];
    bit            e_wr_en = 0;
    logic [AW-1:0] e_trig = '0;
    logic [AW+DW-1:0] exp_q[$];

    function automatic bit crosses(int prev, int cur, int lvl, bit falling);
        if (falling) return (prev > lvl) && (cur <= lvl);
        return (prev < lvl) && (cur >= lvl);
    endfunction

    task automatic model_step();
        int n;
        bit fire;
        e_wr_en = 0;
        if (rst) begin
            m_busy = 0; m_done = 0; m_trig = -1; e_trig = '0;
            run_q.delete();
        end else if (stop_i) begin
            m_busy = 0; m_done = 0;
        end else if (!m_busy) begin
            if (start_i) begin
                m_pre = int'(pre_trig_i); m_post = int'(post_trig_i);
                m_lvl = int'(trig_level_i); m_edge = trig_edge_i;
                m_trig = -1; m_busy = 1; m_done = 0;
                run_q.delete();
            end
        end else if (adc_rdy_i) begin
            n = run_q.size();
            fire = 0;
            e_wr_en = 1;
            exp_q.push_back({AW'(n % DEPTH), adc_data_i});
            if (m_trig < 0 && n >= m_pre) begin
                if (n >= 1 && crosses(run_q[n-1], int'(adc_data_i), m_lvl, m_edge)) fire = 1;
`ifdef ACQ_AUTO_TRIG_EN
                if (n - m_pre + 1 == ATO) fire = 1;
`endif
            end
            run_q.push_back(int'(adc_data_i));
            if (fire) begin
                m_trig = n;
                e_trig = AW'(n % DEPTH);
            end
            if (m_trig >= 0 && run_q.size() == m_trig + m_post + 1) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    function automatic acq_state_t model_state();
        if (!m_busy) return m_done ? ST_DONE : ST_IDLE;
        if (run_q.size() < m_pre) return ST_PRETRIG;
        if (m_trig < 0) return ST_WAIT_TRIG;
        return ST_POSTTRIG;
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(posedge clk_i) begin
        logic [AW+DW-1:0] w;
        model_step();
        #1;
        chk("adc_ack", 32'(adc_ack_o), 32'(adc_rdy_i));
        chk("wr_en", 32'(wr_en_o), 32'(e_wr_en));
        if (wr_en_o && e_wr_en && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_addr", 32'(wr_addr_o), 32'(w[AW+DW-1:DW]));
            chk("wr_data", 32'(wr_data_o), 32'(w[DW-1:0]));
        end else begin
            exp_q.delete();
        end
        chk("trig_addr", 32'(trig_addr_o), 32'(e_trig));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("done", 32'(done_o), 32'(m_done));
        chk("state", 32'(dbg_state_o), 32'(model_state()));
    end

    // Observed write log for the directed literal checks
    logic [AW+DW-1:0] obs_q[$];
    always @(posedge clk_i) begin
        #1;
        if (wr_en_o) obs_q.push_back({wr_addr_o, wr_data_o});
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit s, input bit p, input bit r, input logic [DW-1:0] d);
        start_i = s; stop_i = p; adc_rdy_i = r; adc_data_i = d;
        @(negedge clk_i);
    endtask

    task automatic cfg(input int pre, input int post, input int lvl, input bit fall);
        pre_trig_i = AW'(pre); post_trig_i = AW'(post);
        trig_level_i = DW'(lvl); trig_edge_i = fall;
    endtask

    task automatic abort_and_clear();
        cyc(0, 1, 0, '0);
        cyc(0, 0, 0, '0);
        obs_q.delete();
    endtask

    function automatic logic [31:0] obs_at(int i);
        if (i < obs_q.size()) return 32'(obs_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk_i);
        rst = 1'b0;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_wr_en", 32'(wr_en_o), 0);
        chk("rst_wr_addr", 32'(wr_addr_o), 0);
        chk("rst_trig_addr", 32'(trig_addr_o), 0);
        obs_q.delete();

        // Rising ramp with pre=4, post=4
        cfg(4, 4, 128, 0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, DW'(i * 40));
        cyc(0, 0, 0, '0);
        chk("ramp_writes", obs_q.size(), 9);
        chk("ramp_trig_addr", 32'(trig_addr_o), 4);
        chk("ramp_trig_data", obs_at(4), {4'd4, 8'd160});
        chk("ramp_last", obs_at(8), {4'd8, 8'd64});
        chk("ramp_done", 32'(done_o), 1);
        abort_and_clear();

        // Falling, pre=0 post=0
        cfg(0, 0, 100, 1);
        cyc(1, 0, 0, '0);
        cyc(0, 0, 1, 8'd200); cyc(0, 0, 1, 8'd150); cyc(0, 0, 1, 8'd90);
        cyc(0, 0, 0, '0);
        chk("fall_writes", obs_q.size(), 3);
        chk("fall_trig_addr", 32'(trig_addr_o), 2);
        chk("fall_trig_data", obs_at(2), {4'd2, 8'd90});
        chk("fall_done", 32'(done_o), 1);
        abort_and_clear();

        // Pointer wrap: pre=3, 20 zeros then 255
        cfg(3, 1, 128, 0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'd0);
        cyc(0, 0, 1, 8'd255); cyc(0, 0, 1, 8'd7);
        cyc(0, 0, 0, '0);
        chk("wrap_writes", obs_q.size(), 22);
        chk("wrap_addr16", obs_at(16), {4'd0, 8'd0});
        chk("wrap_trig_addr", 32'(trig_addr_o), 4);
        chk("wrap_done", 32'(done_o), 1);
        abort_and_clear();

        // Stop during POSTTRIG with an accepted sample
        cfg(1, 4, 128, 0);
        cyc(1, 0, 0, '0);
        cyc(0, 0, 1, 8'd0); cyc(0, 0, 1, 8'd10); cyc(0, 0, 1, 8'd200); cyc(0, 0, 1, 8'd201);
        cyc(0, 1, 1, 8'd202);
        cyc(0, 0, 0, '0);
        chk("stop_writes", obs_q.size(), 4);
        chk("stop_busy", 32'(busy_o), 0);
        chk("stop_state", 32'(dbg_state_o), 32'(ST_IDLE));
        chk("stop_trig_addr", 32'(trig_addr_o), 2);
        obs_q.delete();

        // start+stop together from IDLE, then start ignored in WAIT_TRIG
        cfg(0, 2, 128, 0);
        cyc(1, 1, 0, '0);
        chk("startstop_busy", 32'(busy_o), 0);
        cyc(1, 0, 0, '0);
        cyc(0, 0, 1, 8'd10); cyc(0, 0, 1, 8'd20);
        cfg(5, 2, 128, 0);
        cyc(1, 0, 1, 8'd30);
        cyc(0, 0, 0, '0);
        chk("restart_ignored_addr", obs_at(2), {4'd2, 8'd30});
        chk("restart_ignored_state", 32'(dbg_state_o), 32'(ST_WAIT_TRIG));
        abort_and_clear();

        // Flat input: forced trigger only with the auto-trigger feature
        cfg(2, 1, 128, 0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 8'd50);
        cyc(0, 0, 0, '0);
`ifdef ACQ_AUTO_TRIG_EN
        chk("auto_writes", obs_q.size(), 11);
        chk("auto_trig_addr", 32'(trig_addr_o), 9);
        chk("auto_done", 32'(done_o), 1);
`else
        chk("flat_writes", obs_q.size(), 12);
        chk("flat_state", 32'(dbg_state_o), 32'(ST_WAIT_TRIG));
`endif
        abort_and_clear();

        // Randomized traffic; configuration inputs change every cycle so
        // only the values present at start_i may matter.
        for (int i = 0; i < 3000; i++) begin
            cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 999) == 0);
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 9) < 7, DW'($urandom_range(0, 255)));
        end
        rst = 1'b0;
        repeat (4) cyc(0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
